// File: rtl/tick_divider_multi_if.sv
// ---------------------------------------------------------------------------
// tick_divider_multi_if
// Control/status bundle for tick_divider_multi.
//   pause_sig [NUM_CH]      per-channel freeze request
//   div_wr                  one-cycle divisor write strobe
//   div_sel   [SEL_WIDTH]   channel targeted by div_wr
//   div_data  [COUNT_WIDTH] divisor value to load
//   tick_out  [NUM_CH]      one-cycle enable tick per channel
//   sq_out    [NUM_CH]      50% duty square wave per channel
// master drives the controls; slave is the divider block.
// ---------------------------------------------------------------------------
interface tick_divider_multi_if #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 24,
    parameter int SEL_WIDTH   = 2
);
    logic [NUM_CH-1:0]      pause_sig;
    logic                   div_wr;
    logic [SEL_WIDTH-1:0]   div_sel;
    logic [COUNT_WIDTH-1:0] div_data;
    logic [NUM_CH-1:0]      tick_out;
    logic [NUM_CH-1:0]      sq_out;

    modport master (
        output pause_sig, div_wr, div_sel, div_data,
        input  tick_out, sq_out
    );

    modport slave (
        input  pause_sig, div_wr, div_sel, div_data,
        output tick_out, sq_out
    );
endinterface

// File: rtl/tick_divider_multi.sv
// ---------------------------------------------------------------------------
// tick_divider_multi
// Multi-channel programmable tick / square-wave generator. Each channel
// divides clk by its own divisor, can be paused without losing phase, and is
// reprogrammed through a shared single-channel write port.
//   clk  : system clock
//   rst  : asynchronous active-high reset (divisors revert to DEFAULT_DIV)
//   bus  : tick_divider_multi_if.slave (pause/write controls, tick/sq outputs)
// Optional: define TICK_DIVIDER_PAUSE_SYNC_EN to pass every pause bit through
// a 2-flop synchronizer (for raw button inputs); pause then acts 2 cycles later.
// ---------------------------------------------------------------------------

// One divider channel. Priority: write > disabled (div==0) > pause > run.
module tick_divider_ch #(
    parameter int COUNT_WIDTH = 24,
    parameter int DEFAULT_DIV = 6000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pause_i,
    input  logic                   wr_i,
    input  logic [COUNT_WIDTH-1:0] data_i,
    output logic                   tick_o,
    output logic                   sq_o
);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] div_q, div_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   tick_q, tick_d;
    logic                   sq_q, sq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= COUNT_WIDTH'(DEFAULT_DIV);
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (wr_i) begin
            // New period starts at the write edge; sq phase is kept.
            div_d = data_i;
            cnt_d = '0;
        end else if (div_q == '0) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (!pause_i) begin
            // A write always clears cnt, so cnt never passes div-1 and an
            // equality compare is enough for the terminal count.
            if (cnt_q == div_q - ONE) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
endmodule

module tick_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 24,
    parameter int SEL_WIDTH   = 2,
    parameter int DEFAULT_DIV = 6000000
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_divider_multi_if.slave  bus
);
    logic [NUM_CH-1:0] pause_use;

`ifdef TICK_DIVIDER_PAUSE_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.pause_sig;
            sync2_q <= sync1_q;
        end
    end

    assign pause_use = sync2_q;
`else
    assign pause_use = bus.pause_sig;
`endif

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic wr_sel;
            // Selects >= NUM_CH match no channel, so such writes are dropped.
            assign wr_sel = bus.div_wr && (bus.div_sel == SEL_WIDTH'(i));

            tick_divider_ch #(
                .COUNT_WIDTH (COUNT_WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .pause_i (pause_use[i]),
                .wr_i    (wr_sel),
                .data_i  (bus.div_data),
                .tick_o  (bus.tick_out[i]),
                .sq_o    (bus.sq_out[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_tick_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_tick_divider_multi
// Directed bench for tick_divider_multi (3 channels, 8-bit counters,
// DEFAULT_DIV=5). A behavioural model tracks, per channel, the number of
// running cycles since the period was (re)started and the number of ticks
// since the last forced clear; tick is "running cycles is a multiple of div"
// and sq is the tick-count parity. Outputs are compared every negedge, with
// hand-computed literal checks at key cycles.
// ---------------------------------------------------------------------------
module tb_tick_divider_multi;
    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int SW   = 2;
    localparam int DDIV = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tick_divider_multi_if #(.NUM_CH(NCH), .COUNT_WIDTH(CW), .SEL_WIDTH(SW)) bus ();

    tick_divider_multi #(
        .NUM_CH(NCH), .COUNT_WIDTH(CW), .SEL_WIDTH(SW), .DEFAULT_DIV(DDIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_div   [NCH];
    int m_run   [NCH];
    int m_ticks [NCH];
    logic [NCH-1:0] m_tick, m_sq;
    logic [NCH-1:0] m_ps1, m_ps2, m_pause;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DDIV; m_run[i] = 0; m_ticks[i] = 0;
        end
        m_tick = '0; m_sq = '0; m_ps1 = '0; m_ps2 = '0; m_pause = '0;
    endtask

    task automatic model_step();
`ifdef TICK_DIVIDER_PAUSE_SYNC_EN
        m_pause = m_ps2;
        m_ps2   = m_ps1;
        m_ps1   = bus.pause_sig;
`else
        m_pause = bus.pause_sig;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (bus.div_wr && int'(bus.div_sel) == i) begin
                m_div[i] = int'(bus.div_data);
                m_run[i] = 0;
                m_tick[i] = 1'b0;
            end else if (m_div[i] == 0) begin
                m_run[i] = 0; m_ticks[i] = 0; m_tick[i] = 1'b0;
            end else if (m_pause[i]) begin
                m_tick[i] = 1'b0;
            end else begin
                m_run[i]++;
                m_tick[i] = (m_run[i] % m_div[i]) == 0;
                if (m_tick[i]) m_ticks[i]++;
            end
            m_sq[i] = (m_ticks[i] % 2) == 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("model_tick", 32'(bus.tick_out), 32'(m_tick));
            chk("model_sq",   32'(bus.sq_out),   32'(m_sq));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int sel, input int data);
        bus.div_wr   = 1'b1;
        bus.div_sel  = SW'(sel);
        bus.div_data = CW'(data);
        step(1);
        bus.div_wr   = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    // Cycle numbers below count clock edges since reset release.
    initial begin
        bus.pause_sig = '0;
        bus.div_wr    = 1'b0;
        bus.div_sel   = '0;
        bus.div_data  = '0;
        step(2);
        chk("reset_tick", 32'(bus.tick_out), 32'h0);
        chk("reset_sq",   32'(bus.sq_out),   32'h0);
        rst = 1'b0;

        step(5);  // cycle 5
        chk("c5_tick", 32'(bus.tick_out), 32'h7);
        chk("c5_sq",   32'(bus.sq_out),   32'h7);
        step(1);  // cycle 6
        chk("c6_tick", 32'(bus.tick_out), 32'h0);
        chk("c6_sq",   32'(bus.sq_out),   32'h7);
        step(4);  // cycle 10
        chk("c10_tick", 32'(bus.tick_out), 32'h7);
        chk("c10_sq",   32'(bus.sq_out),   32'h0);

        wr(1, 3); // write edge = cycle 11
        chk("c11_tick", 32'(bus.tick_out), 32'h0);
        step(3);  // cycle 14: ch1 first tick, others mid-period
        chk("c14_tick", 32'(bus.tick_out), 32'h2);
        step(1);  // cycle 15: ch0/ch2 keep default phase
        chk("c15_tick", 32'(bus.tick_out), 32'h5);

        step(2);  // cycle 17: ch0 count = 2
        bus.pause_sig = 3'b001;
        step(7);  // edges 18..24 paused
        bus.pause_sig = 3'b000;
`ifndef TICK_DIVIDER_PAUSE_SYNC_EN
        chk("pause_sq_frozen", 32'(bus.sq_out[0]), 32'h1);
        step(2);  // cycle 26
        chk("resume_c26_tick0", 32'(bus.tick_out[0]), 32'h0);
        step(1);  // cycle 27: 3 cycles after release
        chk("resume_c27_tick0", 32'(bus.tick_out[0]), 32'h1);
`else
        step(3);
`endif

        wr(2, 1); // write edge = cycle 28
        chk("div1_wr_tick2", 32'(bus.tick_out[2]), 32'h0);
        chk("div1_wr_sq2",   32'(bus.sq_out[2]),   32'h1);
        step(1);  // cycle 29
        chk("div1_c29_tick2", 32'(bus.tick_out[2]), 32'h1);
        chk("div1_c29_sq2",   32'(bus.sq_out[2]),   32'h0);
        step(1);  // cycle 30
        chk("div1_c30_tick2", 32'(bus.tick_out[2]), 32'h1);
        chk("div1_c30_sq2",   32'(bus.sq_out[2]),   32'h1);

        wr(2, 0); // write edge = cycle 31
        step(1);  // cycle 32
        chk("div0_tick2", 32'(bus.tick_out[2]), 32'h0);
        chk("div0_sq2",   32'(bus.sq_out[2]),   32'h0);
        step(3);  // cycle 35
        chk("div0_hold_tick2", 32'(bus.tick_out[2]), 32'h0);
        chk("div0_hold_sq2",   32'(bus.sq_out[2]),   32'h0);

        wr(3, 1); // out-of-range select, cycle 36
        step(2);  // cycle 38: ch1 still on div=3 phase
        chk("oor_tick1", 32'(bus.tick_out[1]), 32'h1);
        chk("oor_tick2", 32'(bus.tick_out[2]), 32'h0);

        bus.pause_sig = 3'b001;
        wr(0, 4); // write+pause, edge = cycle 39
        step(4);  // cycles 40..43 held
        bus.pause_sig = 3'b000;
`ifndef TICK_DIVIDER_PAUSE_SYNC_EN
        step(3);  // cycle 46
        chk("wrpause_c46_tick0", 32'(bus.tick_out[0]), 32'h0);
        step(1);  // cycle 47: 4 cycles after release
        chk("wrpause_c47_tick0", 32'(bus.tick_out[0]), 32'h1);
`else
        step(4);
`endif

        #2 rst = 1'b1;
        #1;
        chk("async_rst_tick", 32'(bus.tick_out), 32'h0);
        chk("async_rst_sq",   32'(bus.sq_out),   32'h0);
        step(1);
        rst = 1'b0;
        step(3);  // cycle 3: ch1 back on DEFAULT_DIV, no tick
        chk("post_rst_c3_tick", 32'(bus.tick_out), 32'h0);
        step(2);  // cycle 5
        chk("post_rst_c5_tick", 32'(bus.tick_out), 32'h7);
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
